// File: rtl/exc_ctrl.sv
// Exception / interrupt sequencer.
// Arbitrates synchronous exceptions and four masked external interrupts.
// Captures the exception PC and cause code, then walks the pipeline
// through TAKE -> FLUSH (FLUSH_CYCLES cycles) -> VECTOR. A legal return
// from exception goes through the single-cycle RET state instead.
// All outputs except epc/cause are a pure decode of the state register,
// so no input reaches an output through combinational logic.
module exc_ctrl #(
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0080,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        inst_valid,
    input  logic        illegal,
    input  logic        syscall,
    input  logic        rfe_req,
    input  logic [3:0]  irq,
    input  logic [3:0]  irq_mask,
    input  logic        IE_c,
    input  logic        s_u_c,
    output logic        exception,
    output logic        rfe,
    output logic        flush,
    output logic [1:0]  pc_sel,
    output logic [31:0] pc_target,
    output logic [31:0] epc,
    output logic [3:0]  cause,
    output logic        busy
);

    // Sequencer states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TAKE   = 3'd1;
    localparam logic [2:0] S_FLUSH  = 3'd2;
    localparam logic [2:0] S_VECTOR = 3'd3;
    localparam logic [2:0] S_RET    = 3'd4;

    // Redirect selector encodings
    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_VECTOR = 2'b01;
    localparam logic [1:0] PC_EPC    = 2'b10;

    // Cause codes for the synchronous exceptions
    localparam logic [3:0] CAUSE_ILLEGAL  = 4'h8;
    localparam logic [3:0] CAUSE_SYSCALL  = 4'h9;
    localparam logic [3:0] CAUSE_USER_RFE = 4'hA;

    // Value of the flush counter in the last FLUSH cycle
    localparam logic [3:0] FCNT_LAST = 4'(FLUSH_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  fcnt_q,  fcnt_d;
    logic [31:0] epc_q,   epc_d;
    logic [3:0]  cause_q, cause_d;

    // ------------------------------------------------------------------
    // Interrupt arbitration: lowest-index enabled line wins.
    // lower_any[i] is set when any line below i is active, so exactly
    // one bit of irq_first can be high.
    // ------------------------------------------------------------------
    logic [3:0] irq_act;
    logic [3:0] lower_any;
    logic [3:0] irq_first;
    logic [1:0] irq_idx;
    logic       irq_evt;

    assign irq_act      = irq & irq_mask;
    assign lower_any[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_irq_pri
            assign irq_first[gi] = irq_act[gi] & ~lower_any[gi];
            if (gi < 3) begin : g_chain
                assign lower_any[gi+1] = lower_any[gi] | irq_act[gi];
            end
        end
    endgenerate

    assign irq_idx = {irq_first[3] | irq_first[2], irq_first[3] | irq_first[1]};
    assign irq_evt = IE_c & (|irq_act);

    // ------------------------------------------------------------------
    // Event qualification. Only meaningful while IDLE; the FSM ignores
    // these terms in every other state, which is what drops synchronous
    // requests that arrive during a flush.
    // ------------------------------------------------------------------
    logic       ill_evt;
    logic       sys_evt;
    logic       urfe_evt;
    logic       lrfe_evt;
    logic       take_evt;
    logic [3:0] evt_cause;

    assign ill_evt  = inst_valid & illegal;
    assign sys_evt  = inst_valid & syscall;
    assign urfe_evt = inst_valid & rfe_req & s_u_c;
    assign lrfe_evt = inst_valid & rfe_req & ~s_u_c;
    assign take_evt = ill_evt | sys_evt | urfe_evt | irq_evt;

    // Priority encode the cause of the winning event
    always_comb begin
        evt_cause = {2'b01, irq_idx};
        if (ill_evt) begin
            evt_cause = CAUSE_ILLEGAL;
        end else if (sys_evt) begin
            evt_cause = CAUSE_SYSCALL;
        end else if (urfe_evt) begin
            evt_cause = CAUSE_USER_RFE;
        end
    end

    // Next-state, flush counter and exception capture
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        case (state_q)
            S_IDLE: begin
                if (take_evt) begin
                    // For an interrupt pc_in has not executed yet, so
                    // saving it makes the return re-execute it.
                    epc_d   = pc_in;
                    cause_d = evt_cause;
                    fcnt_d  = 4'd0;
                    state_d = S_TAKE;
                end else if (lrfe_evt) begin
                    state_d = S_RET;
                end
            end
            S_TAKE: begin
                state_d = S_FLUSH;
            end
            S_FLUSH: begin
                fcnt_d = fcnt_q + 4'd1;
                if (fcnt_q == FCNT_LAST) begin
                    state_d = S_VECTOR;
                end
            end
            S_VECTOR: begin
                state_d = S_IDLE;
            end
            S_RET: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and capture registers, cleared asynchronously by rst low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            fcnt_q  <= 4'd0;
            epc_q   <= 32'd0;
            cause_q <= 4'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    // Moore output decode from the state register only
    always_comb begin
        exception = 1'b0;
        rfe       = 1'b0;
        flush     = 1'b0;
        pc_sel    = PC_SEQ;
        pc_target = 32'd0;
        case (state_q)
            S_TAKE: begin
                exception = 1'b1;
                flush     = 1'b1;
            end
            S_FLUSH: begin
                flush = 1'b1;
            end
            S_VECTOR: begin
                flush     = 1'b1;
                pc_sel    = PC_VECTOR;
                pc_target = VECTOR_ADDR;
            end
            S_RET: begin
                rfe       = 1'b1;
                flush     = 1'b1;
                pc_sel    = PC_EPC;
                pc_target = epc_q;
            end
            default: begin
                exception = 1'b0;
            end
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign epc   = epc_q;
    assign cause = cause_q;

endmodule
